// File: rtl/iir_pkg.sv
// iir_pkg: shared definitions for the iir_biquad_cascade slice.
//   - state_t      : sequencer states (IDLE, MAC, DRAIN, WB, DONE)
//   - K_B0..K_A2   : coefficient index within a section (address = section*5 + k)
//   - unity_coef   : Q-format value of 1.0 for a given number of fractional bits
//   - round_sat    : round-half-up, arithmetic shift, clamp to a signed width
//   - sat_hit      : flags whether round_sat had to clamp
package iir_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC   = 3'd1,
    S_DRAIN = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] K_B0 = 3'd0;
  localparam logic [2:0] K_B1 = 3'd1;
  localparam logic [2:0] K_B2 = 3'd2;
  localparam logic [2:0] K_A1 = 3'd3;
  localparam logic [2:0] K_A2 = 3'd4;

  // 1.0 in a Q format with 'frac' fractional bits.
  function automatic logic [63:0] unity_coef(input int frac);
    return 64'd1 << frac;
  endfunction

  // Add half an LSB of the output, then drop 'frac' bits (floor shift).
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] acc,
                                                     input int frac);
    logic signed [63:0] half;
    half = 64'sd1 <<< (frac - 1);
    return (acc + half) >>> frac;
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] acc, input int frac,
                                   input int dw);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = round_shift(acc, frac);
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    return (r > hi) || (r < lo);
  endfunction

  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int frac, input int dw);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = round_shift(acc, frac);
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) begin
      return hi;
    end else if (r < lo) begin
      return lo;
    end else begin
      return r;
    end
  endfunction

endpackage

// File: rtl/iir_mac.sv
// iir_mac: registered signed multiplier feeding an ACC_W accumulator.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   a, b            : signed multiplier operands (product registered, 1 cycle)
//   acc_clear       : load zero into the accumulator
//   acc_en, acc_sub : add (or subtract) the registered product
//   acc             : accumulator value
module iir_mac #(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int ACC_W = 40
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  input  logic                    acc_clear,
  input  logic                    acc_en,
  input  logic                    acc_sub,
  output logic signed [ACC_W-1:0] acc
);

  localparam int P_W = A_W + B_W;

  (* use_dsp = "yes" *) logic signed [P_W-1:0] prod;
  logic signed [ACC_W-1:0] prod_ext;

  assign prod_ext = {{(ACC_W - P_W){prod[P_W-1]}}, prod};

  // Multiply every cycle; the accumulator consumes the previous cycle's product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod <= '0;
      acc  <= '0;
    end else begin
      prod <= P_W'(a) * P_W'(b);
      if (acc_clear) begin
        acc <= '0;
      end else if (acc_en) begin
        acc <= acc_sub ? (acc - prod_ext) : (acc + prod_ext);
      end else begin
        acc <= acc;
      end
    end
  end

endmodule

// File: rtl/iir_biquad_cascade.sv
// iir_biquad_cascade: NUM_CHANNELS x NUM_SECTIONS Direct Form I biquads sharing
// one registered multiplier. Channel is the outer loop, section the inner one;
// each (channel, section) pass takes 5 MAC + 1 DRAIN + 1 WB cycles.
// Ports:
//   clk, reset                   : clock, asynchronous active-low reset
//   sample_valid/sample_in       : frame strobe and packed channel samples
//   sample_ready                 : high only while IDLE can take a frame
//   coef_we/coef_addr/coef_wdata : shadow-bank write (addr = section*5 + k)
//   coef_commit                  : copy shadow to active at the next idle point
//   clear_state                  : zero delay lines and sat_flag (when idle)
//   filtered_output/output_valid : packed results and one-cycle strobe
//   sat_flag                     : sticky saturation indicator
//   overrun                      : pulse when a frame arrives while busy
module iir_biquad_cascade
  import iir_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int COEF_W       = 16,
  parameter int COEF_FRAC    = 14,
  parameter int NUM_SECTIONS = 3,
  parameter int NUM_CHANNELS = 2,
  parameter int ACC_W        = 40
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 sample_valid,
  input  logic [NUM_CHANNELS*DATA_W-1:0]       sample_in,
  output logic                                 sample_ready,
  input  logic                                 coef_we,
  input  logic [$clog2(5*NUM_SECTIONS)-1:0]    coef_addr,
  input  logic [COEF_W-1:0]                    coef_wdata,
  input  logic                                 coef_commit,
  input  logic                                 clear_state,
  output logic [NUM_CHANNELS*DATA_W-1:0]       filtered_output,
  output logic                                 output_valid,
  output logic                                 sat_flag,
  output logic                                 overrun
);

  localparam int NCOEF  = 5 * NUM_SECTIONS;
  localparam int NLINE  = NUM_SECTIONS * NUM_CHANNELS;
  localparam int SEC_W  = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
  localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int LINE_W = (NLINE > 1) ? $clog2(NLINE) : 1;
  localparam int CIDX_W = $clog2(NCOEF);
  localparam logic [63:0] UNITY_64 = unity_coef(COEF_FRAC);
  localparam logic signed [COEF_W-1:0] UNITY = UNITY_64[COEF_W-1:0];
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(NUM_SECTIONS - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CHANNELS - 1);

  state_t                    state;
  logic [2:0]                k;
  logic [SEC_W-1:0]          sec;
  logic [CH_W-1:0]           ch;
  logic signed [DATA_W-1:0]  samp [NUM_CHANNELS];
  logic signed [DATA_W-1:0]  res  [NUM_CHANNELS];
  logic signed [DATA_W-1:0]  stage_y;
  logic signed [DATA_W-1:0]  x1 [NLINE];
  logic signed [DATA_W-1:0]  x2 [NLINE];
  logic signed [DATA_W-1:0]  y1 [NLINE];
  logic signed [DATA_W-1:0]  y2 [NLINE];
  logic signed [COEF_W-1:0]  shadow [NCOEF];
  logic signed [COEF_W-1:0]  active [NCOEF];
  logic                      commit_pend;
  logic                      clear_pend;

  logic [LINE_W-1:0]         line;
  logic [CIDX_W-1:0]         cidx;
  logic signed [DATA_W-1:0]  x_cur;
  logic signed [DATA_W-1:0]  mul_a;
  logic signed [COEF_W-1:0]  mul_b;
  logic                      mac_clear;
  logic                      mac_en;
  logic                      mac_sub;
  logic signed [ACC_W-1:0]   acc;
  logic signed [DATA_W-1:0]  y_new;
  logic                      sat_now;
  logic                      do_commit;
  logic                      do_clear;

  // Operand selection, MAC control and pending-action decode.
  always_comb begin
    line  = LINE_W'(int'(ch) * NUM_SECTIONS + int'(sec));
    cidx  = CIDX_W'(int'(sec) * 5 + int'(k));
    x_cur = (sec == '0) ? samp[ch] : stage_y;
    case (k)
      K_B0:    mul_a = x_cur;
      K_B1:    mul_a = x1[line];
      K_B2:    mul_a = x2[line];
      K_A1:    mul_a = y1[line];
      K_A2:    mul_a = y2[line];
      default: mul_a = '0;
    endcase
    mul_b = active[cidx];
    // Product for tap k lands one cycle later, so the feedback taps (k=3,4)
    // are subtracted at k=4 and in DRAIN.
    mac_clear = (state == S_MAC) && (k == K_B0);
    mac_en    = ((state == S_MAC) && (k != K_B0)) || (state == S_DRAIN);
    mac_sub   = ((state == S_MAC) && (k == K_A2)) || (state == S_DRAIN);
    y_new     = DATA_W'(round_sat(64'(acc), COEF_FRAC, DATA_W));
    sat_now   = sat_hit(64'(acc), COEF_FRAC, DATA_W);
    do_commit = (state == S_IDLE) && (commit_pend || coef_commit);
    do_clear  = (state == S_IDLE) && (clear_pend || clear_state);
  end

  iir_mac #(
    .A_W   (DATA_W),
    .B_W   (COEF_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .a         (mul_a),
    .b         (mul_b),
    .acc_clear (mac_clear),
    .acc_en    (mac_en),
    .acc_sub   (mac_sub),
    .acc       (acc)
  );

  // Sequencer: frame capture, pass counters, outputs and pending flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      k               <= 3'd0;
      sec             <= '0;
      ch              <= '0;
      stage_y         <= '0;
      sample_ready    <= 1'b1;
      output_valid    <= 1'b0;
      overrun         <= 1'b0;
      sat_flag        <= 1'b0;
      filtered_output <= '0;
      commit_pend     <= 1'b0;
      clear_pend      <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        samp[c] <= '0;
        res[c]  <= '0;
      end
    end else begin
      overrun      <= sample_valid & ~sample_ready;
      output_valid <= 1'b0;
      commit_pend  <= do_commit ? 1'b0 : (commit_pend | coef_commit);
      clear_pend   <= do_clear ? 1'b0 : (clear_pend | clear_state);
      case (state)
        S_IDLE: begin
          if (sample_ready && sample_valid) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
              samp[c] <= sample_in[c*DATA_W +: DATA_W];
            end
            k            <= 3'd0;
            sec          <= '0;
            ch           <= '0;
            sample_ready <= 1'b0;
            state        <= S_MAC;
          end else begin
            sample_ready <= 1'b1;
            state        <= S_IDLE;
          end
          if (do_clear) begin
            sat_flag <= 1'b0;
          end else begin
            sat_flag <= sat_flag;
          end
        end
        S_MAC: begin
          if (k == K_A2) begin
            state <= S_DRAIN;
          end else begin
            k     <= k + 3'd1;
            state <= S_MAC;
          end
        end
        S_DRAIN: begin
          state <= S_WB;
        end
        S_WB: begin
          if (sat_now) begin
            sat_flag <= 1'b1;
          end else begin
            sat_flag <= sat_flag;
          end
          k       <= 3'd0;
          stage_y <= y_new;
          if (sec == SEC_LAST) begin
            res[ch] <= y_new;
            sec     <= '0;
            if (ch == CH_LAST) begin
              state <= S_DONE;
            end else begin
              ch    <= ch + CH_W'(1);
              state <= S_MAC;
            end
          end else begin
            sec   <= sec + SEC_W'(1);
            state <= S_MAC;
          end
        end
        S_DONE: begin
          for (int c = 0; c < NUM_CHANNELS; c++) begin
            filtered_output[c*DATA_W +: DATA_W] <= res[c];
          end
          output_valid <= 1'b1;
          // A pending commit/clear takes one IDLE cycle before ready rises.
          sample_ready <= ~(commit_pend | coef_commit | clear_pend | clear_state);
          state        <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Coefficient banks: shadow writes any time, active copy only while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCOEF; i++) begin
        shadow[i] <= ((i % 5) == 0) ? UNITY : '0;
        active[i] <= ((i % 5) == 0) ? UNITY : '0;
      end
    end else begin
      for (int i = 0; i < NCOEF; i++) begin
        if (coef_we && (int'(coef_addr) == i)) begin
          shadow[i] <= coef_wdata;
        end else begin
          shadow[i] <= shadow[i];
        end
        if (do_commit) begin
          active[i] <= (coef_we && (int'(coef_addr) == i)) ? coef_wdata : shadow[i];
        end else begin
          active[i] <= active[i];
        end
      end
    end
  end

  // Delay lines: shift at write-back, zero on an idle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NLINE; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else if (do_clear) begin
      for (int i = 0; i < NLINE; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else if (state == S_WB) begin
      x2[line] <= x1[line];
      x1[line] <= x_cur;
      y2[line] <= y1[line];
      y1[line] <= y_new;
    end else begin
      x1[line] <= x1[line];
    end
  end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Scoreboard bench for iir_biquad_cascade: a floating-free integer model of the
// cascade predicts every frame at issue time; a monitor pops and compares.
module tb_iir_biquad_cascade;

  localparam int DW    = 16;
  localparam int NS    = 3;
  localparam int NC    = 2;
  localparam int NCOEF = NS * 5;
  localparam int LAT   = 7 * NS * NC + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              sample_valid = 1'b0;
  logic [NC*DW-1:0]  sample_in = '0;
  logic              sample_ready;
  logic              coef_we = 1'b0;
  logic [3:0]        coef_addr = '0;
  logic [15:0]       coef_wdata = '0;
  logic              coef_commit = 1'b0;
  logic              clear_state = 1'b0;
  logic [NC*DW-1:0]  filtered_output;
  logic              output_valid;
  logic              sat_flag;
  logic              overrun;

  iir_biquad_cascade #(
    .DATA_W(DW), .COEF_W(16), .COEF_FRAC(14),
    .NUM_SECTIONS(NS), .NUM_CHANNELS(NC), .ACC_W(40)
  ) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
    .sample_ready(sample_ready), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .coef_commit(coef_commit), .clear_state(clear_state),
    .filtered_output(filtered_output), .output_valid(output_valid),
    .sat_flag(sat_flag), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NC*DW-1:0] out;
    logic             sat;
    int               acc_cyc;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    passes = 0;
  int    ov_cnt = 0;
  int    or_cnt = 0;

  // Reference model state
  longint m_sh [NCOEF];
  longint m_act[NCOEF];
  longint mx1[NC][NS];
  longint mx2[NC][NS];
  longint my1[NC][NS];
  longint my2[NC][NS];
  logic   m_sat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic void model_clear();
    for (int c = 0; c < NC; c++)
      for (int s = 0; s < NS; s++) begin
        mx1[c][s] = 0; mx2[c][s] = 0; my1[c][s] = 0; my2[c][s] = 0;
      end
    m_sat = 1'b0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NCOEF; i++) begin
      m_sh[i]  = ((i % 5) == 0) ? 64'sd16384 : 64'sd0;
      m_act[i] = m_sh[i];
    end
    model_clear();
  endfunction

  // y = clamp(round((b0 x + b1 x1 + b2 x2 - a1 y1 - a2 y2) / 2^14)), cascaded.
  function automatic logic [NC*DW-1:0] model_frame(input logic [NC*DW-1:0] inp);
    logic [NC*DW-1:0] out;
    longint v, acc, y;
    out = '0;
    for (int c = 0; c < NC; c++) begin
      v = longint'($signed(inp[c*DW +: DW]));
      for (int s = 0; s < NS; s++) begin
        acc = m_act[s*5] * v + m_act[s*5+1] * mx1[c][s] + m_act[s*5+2] * mx2[c][s]
            - m_act[s*5+3] * my1[c][s] - m_act[s*5+4] * my2[c][s];
        y = (acc + 64'sd8192) >>> 14;
        if (y > 32767) begin y = 32767; m_sat = 1'b1; end
        else if (y < -32768) begin y = -32768; m_sat = 1'b1; end
        mx2[c][s] = mx1[c][s]; mx1[c][s] = v;
        my2[c][s] = my1[c][s]; my1[c][s] = y;
        v = y;
      end
      out[c*DW +: DW] = DW'(v);
    end
    return out;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!sample_ready && t < 300) begin @(negedge clk); t++; end
    if (!sample_ready) fail_now("ready_timeout");
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || !sample_ready) && t < 400) begin @(negedge clk); t++; end
    if (sb.size() != 0 || !sample_ready) fail_now("idle_timeout");
  endtask

  task automatic send_frame(input logic [NC*DW-1:0] inp);
    exp_t e;
    wait_ready();
    sample_valid = 1'b1;
    sample_in    = inp;
    @(negedge clk);
    sample_valid = 1'b0;
    e.out     = model_frame(inp);
    e.sat     = m_sat;
    e.acc_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic write_coef(input logic [3:0] addr, input logic [15:0] val, input logic commit);
    coef_we = 1'b1; coef_addr = addr; coef_wdata = val; coef_commit = commit;
    @(negedge clk);
    coef_we = 1'b0; coef_commit = 1'b0;
    m_sh[addr] = longint'($signed(val));
    if (commit) for (int i = 0; i < NCOEF; i++) m_act[i] = m_sh[i];
  endtask

  task automatic pulse_clear();
    clear_state = 1'b1;
    @(negedge clk);
    clear_state = 1'b0;
    model_clear();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 64'(sample_ready), 64'd1);
    check({tag, "_valid"}, 64'(output_valid), 64'd0);
    check({tag, "_sat"}, 64'(sat_flag), 64'd0);
    check({tag, "_overrun"}, 64'(overrun), 64'd0);
    check({tag, "_out"}, 64'(filtered_output), 64'd0);
  endtask

  // Monitor: compare every presented frame against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (overrun) or_cnt++;
      if (output_valid) begin
        ov_cnt++;
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output: got valid with empty scoreboard (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("frame_out", 64'(filtered_output), 64'(e.out));
          check("sat_flag", 64'(sat_flag), 64'(e.sat));
          check("latency", 64'(cyc - e.acc_cyc), 64'(LAT));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ov0, or0;
    model_reset();
    tick(3);
    check_reset_vals("reset");
    reset = 1'b1;
    tick(2);

    // Unity passthrough after reset
    send_frame({16'hC000, 16'h4000});
    wait_idle();

    // One-pole: y = 0.5 x + 0.5 y1 on section 0
    pulse_clear();
    write_coef(4'd0, 16'h2000, 1'b0);
    write_coef(4'd3, 16'hE000, 1'b1);
    for (int i = 0; i < 4; i++) send_frame({16'h0000, 16'h1000});
    wait_idle();

    // Saturation, stickiness, clear
    pulse_clear();
    write_coef(4'd0, 16'h7FFF, 1'b0);
    write_coef(4'd3, 16'h0000, 1'b1);
    send_frame({16'h0000, 16'h7000});
    wait_idle();
    write_coef(4'd0, 16'h4000, 1'b1);
    send_frame({16'h0100, 16'h0200});
    send_frame({16'hFF00, 16'h0300});
    wait_idle();
    pulse_clear();
    tick(2);
    check("sat_cleared", 64'(sat_flag), 64'd0);

    // Overrun: second strobe 10 cycles into a frame
    ov0 = ov_cnt; or0 = or_cnt;
    send_frame({16'h1234, 16'hABCD});
    tick(9);
    sample_valid = 1'b1; sample_in = {16'h7777, 16'h7777};
    @(negedge clk);
    sample_valid = 1'b0;
    wait_idle();
    check("overrun_pulses", 64'(or_cnt - or0), 64'd1);
    check("overrun_valids", 64'(ov_cnt - ov0), 64'd1);

    // Commit mid-frame (write and commit in the same cycle)
    send_frame({16'h2000, 16'hE000});
    tick(10);
    write_coef(4'd0, 16'h2000, 1'b1);
    wait_idle();
    send_frame({16'h0800, 16'hF000});
    // Latched clear while busy
    tick(5);
    pulse_clear();
    wait_idle();
    send_frame({16'h0400, 16'h0400});
    wait_idle();

    // Mid-frame reset
    ov0 = ov_cnt;
    send_frame({16'h5555, 16'h1111});
    tick(19);
    reset = 1'b0;
    sb.delete();
    tick(2);
    check_reset_vals("midreset");
    reset = 1'b1;
    model_reset();
    tick(1);
    check("midreset_no_valid", 64'(ov_cnt - ov0), 64'd0);
    send_frame({16'h8001, 16'h3C3C});
    wait_idle();

    // Randomized frames, coefficient updates and clears
    for (int it = 0; it < 24; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 3) write_coef(4'($urandom_range(0, NCOEF - 1)),
                            16'($urandom_range(0, 16'h6000)) - 16'h3000, 1'b1);
      else if (r == 3) pulse_clear();
      send_frame({16'($urandom), 16'($urandom)});
      if (r == 4) begin
        tick(12);
        write_coef(4'($urandom_range(0, NCOEF - 1)),
                   16'($urandom_range(0, 16'h6000)) - 16'h3000, 1'b1);
        wait_idle();
      end
      if (r >= 8) wait_idle();
    end
    wait_idle();
    tick(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/iir_biquad_cascade.md
# iir_biquad_cascade

Parametrised multi-channel, multi-section biquad IIR filter built around a single time-multiplexed registered multiplier, intended for DSP-slice inference on iCE40UP5K. Each frame of `NUM_CHANNELS` samples passes through `NUM_SECTIONS` cascaded Direct Form I biquads. Coefficients are runtime-writable through a double-buffered bank. The block sits between the audio sample source and the output formatter, and replaces per-filter single-biquad instances.

## Interface
- `DATA_W`, 16: sample width, signed.
- `COEF_W`, 16: coefficient width, signed, Q2.(`COEF_W`-2).
- `COEF_FRAC`, 14: coefficient fractional bits.
- `NUM_SECTIONS`, 3: cascaded biquads per channel.
- `NUM_CHANNELS`, 2: channels per frame.
- `ACC_W`, 40: accumulator width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `sample_valid` in 1: frame strobe.
- `sample_in` in `NUM_CHANNELS*DATA_W`: channel c occupies bits [c*DATA_W +: DATA_W].
- `sample_ready` in/out: out 1; high only in IDLE.
- `coef_we` in 1: write to the shadow bank.
- `coef_addr` in clog2(5*`NUM_SECTIONS`): address = section*5 + k, where k: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
- `coef_wdata` in `COEF_W`: coefficient value.
- `coef_commit` in 1: request shadow-to-active copy.
- `clear_state` in 1: zero all delay lines.
- `filtered_output` out `NUM_CHANNELS*DATA_W`: same packing as `sample_in`.
- `output_valid` out 1: one-cycle strobe.
- `sat_flag` out 1: sticky; any section saturated since the last clear.
- `overrun` out 1: one-cycle pulse when a frame is dropped.

## Operation
- **Per-section computation:** acc = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2.
  - Each product is full-precision `DATA_W+COEF_W` bits, sign-extended to `ACC_W`.
  - y = saturate_DATA_W((acc + 2^(COEF_FRAC−1)) >>> COEF_FRAC).
- **Cascade:** section s output is the input of section s+1. The last section's output goes to `filtered_output`.
- **Delay-line state:** x1, x2, y1, y2 are stored per (channel, section) as `DATA_W` values, i.e. the saturated y.
- **State machine:**
  - IDLE: wait for `sample_valid`.
  - MAC: k = 0..4, one product issued per cycle.
  - DRAIN: last product accumulated.
  - WB: round, saturate, update delay line, advance section, then channel.
  - DONE: outputs registered, `output_valid` = 1, return to IDLE.
  - Channel is the outer loop; section is the inner loop.
- **Frame capture:** `sample_valid` while not ready drops the frame and pulses `overrun`. Delay lines are unchanged.
- **Coefficient writes:** `coef_we` writes the shadow bank in any state.
  - `coef_commit` sets a pending bit.
  - The active bank copies from the shadow in IDLE, in the cycle before `sample_ready` reasserts, so a frame never mixes banks.
  - Commit and write in the same cycle: the written value is included in the copy.
- **`clear_state`:**
  - Honoured in IDLE only; latched if asserted while busy.
  - Zeros x1/x2/y1/y2 for all channels and sections.
  - Also clears `sat_flag`.
- **Reset values:**
  - Both coefficient banks: b0 = 1<<COEF_FRAC, all others 0, giving unity passthrough.
  - Delay lines zero, `filtered_output` 0, `output_valid` 0, `sat_flag` 0, `overrun` 0, `sample_ready` 1, state IDLE.
- **Reset mid-frame:** abort immediately; no `output_valid`; all state returns to the reset values.

## Timing
- **Per (channel, section) pass:** 7 cycles (5 MAC, 1 DRAIN, 1 WB). The multiplier output is registered with one cycle of latency.
- **Frame latency:** `sample_valid` accepted on edge 0 → `output_valid` high on edge 7·NUM_SECTIONS·NUM_CHANNELS + 1. This is edge 43 for the defaults.
- **Ready timing:** `sample_ready` drops on the edge after acceptance. It reasserts on the edge after DONE, or one cycle later if a commit or clear is pending.
- **Throughput:** one frame per 44 cycles for the defaults.
- **Output hold:** `filtered_output` holds until the next DONE.

## Structure
- **Package `iir_pkg`:**
  - state enum
  - coefficient index constants (`K_B0`..`K_A2`)
  - unity-coefficient constant
  - round-and-saturate function
- **Sub-module `iir_mac`:** registered signed multiplier plus `ACC_W` accumulator, with clear/accumulate/subtract controls. Carries the DSP attribute.
- **Storage:** delay lines and coefficient banks are register arrays in the top level.

## Test plan
- **Reset passthrough:** reset, then frame {0x4000, 0xC000} → after 43 cycles `filtered_output` = {0x4000, 0xC000}, `sat_flag` 0.
- **One-pole response:**
  - Setup: section0 b0 = 0x2000, a1 = 0xE000, others 0; sections 1–2 unity; commit.
  - Stimulus: ch0 step 0x1000.
  - Required: successive outputs 0x0800, 0x0C00, 0x0E00, 0x0F00.
  - ch1 is independent: zero input → 0x0000.
- **Saturation:** section0 b0 = 0x7FFF, input 0x7000 → output 0x7FFF, `sat_flag` 1. `sat_flag` stays 1 through subsequent unity frames until `clear_state`.
- **Overrun:** second `sample_valid` 10 cycles after the first → `overrun` pulses once. Exactly one `output_valid`; first frame result unaffected.
- **Commit atomicity:** write b0 = 0x2000 and commit mid-frame → the current frame uses the old coefficients. The next frame output equals half the input.
- **Mid-frame reset:** assert `reset` low at cycle 20 → no `output_valid`. All outputs return to the reset values; the next frame is passthrough.
